spi_master_fifo: RTL

//  Parametrised SPI output master for memory-mapped peripherals (OLED/LCD and later devices).
//  CPU stores push words into a TX FIFO; the block serialises them MSB-first with programmable CPOL/CPHA.
//  Per-frame D/C flag; power-control commands bypass the FIFO; status (level/busy/overflow) readable.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_fifo.sv | 48 ++++
 rtl/spi_master_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI output master: FSM state encoding, din field helper
// and the default SCK divider.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int FREQDIV_DEFAULT = 25;

  // din carries {power_cmd, dc, payload}; the power-command flag sits above the D/C bit
  function automatic int pwr_bit(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// First-word-fall-through synchronous FIFO with power-of-two depth; pointers carry an
// extra wrap bit so full/empty/level fall straight out of the pointer difference.
module spi_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  // A push into a full FIFO is still legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI output master: queued frames serialised MSB-first with per-frame CPOL/CPHA and D/C,
// plus power-control commands that bypass the queue and a sticky overflow flag.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FREQDIV    = FREQDIV_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              wr,
  input  logic [DATA_W+1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic              ovf,
  output logic              cs_,
  output logic              sck,
  output logic              sdo,
  output logic              dc_,
  output logic              res_,
  output logic              pmoden,
  output logic              vccen
);

  localparam int PWR = pwr_bit(DATA_W);
  localparam int CW  = $clog2(FREQDIV);
  localparam int BW  = $clog2(2 * DATA_W);

  spi_state_t        state, state_nx;
  logic [CW-1:0]     cnt2;
  logic [BW-1:0]     bitc;
  logic [DATA_W-1:0] shreg;
  logic              cpha_q;
  logic [DATA_W:0]   fifo_dout;
  logic              pop;
  logic              push;
  logic              drop;
  logic              cnt_done;
  logic              last_half;

  assign push      = wr && !din[PWR] && (!full || pop);
  assign drop      = wr && !din[PWR] && full && !pop;
  assign cnt_done  = (cnt2 == CW'(FREQDIV - 1));
  assign last_half = (bitc == BW'(2 * DATA_W - 1));
  assign busy      = (state != IDLE);

  spi_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (push),
    .pop    (pop),
    .din    (din[DATA_W:0]),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE:  if (!empty) begin
               pop      = 1'b1;
               state_nx = SETUP;
             end
      SETUP: if (cnt_done) state_nx = SHIFT;
      SHIFT: if (cnt_done && last_half) state_nx = HOLD;
      HOLD:  if (cnt_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Even half-periods end on a leading SCK edge, odd ones on a trailing edge
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt2   <= '0;
      bitc   <= '0;
      shreg  <= '0;
      cpha_q <= 1'b0;
      cs_    <= 1'b1;
      sck    <= 1'b0;
      sdo    <= 1'b0;
      dc_    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt2 <= '0;
          bitc <= '0;
          if (pop) begin
            cs_    <= 1'b0;
            sck    <= cpol;
            cpha_q <= cpha;
            dc_    <= fifo_dout[DATA_W];
            if (!cpha) begin
              sdo   <= fifo_dout[DATA_W-1];
              shreg <= fifo_dout[DATA_W-1:0] << 1;
            end else begin
              shreg <= fifo_dout[DATA_W-1:0];
            end
          end
        end
        SETUP: cnt2 <= cnt_done ? '0 : cnt2 + 1'b1;
        SHIFT: begin
          if (cnt_done) begin
            cnt2 <= '0;
            sck  <= ~sck;
            bitc <= last_half ? '0 : bitc + 1'b1;
            if (bitc[0] != cpha_q) begin
              sdo   <= shreg[DATA_W-1];
              shreg <= shreg << 1;
            end
          end else begin
            cnt2 <= cnt2 + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_done) begin
            cnt2 <= '0;
            cs_  <= 1'b1;
          end else begin
            cnt2 <= cnt2 + 1'b1;
          end
        end
        default: cnt2 <= '0;
      endcase
    end
  end

  // Display reset releases on the first edge; power commands act regardless of frame state
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      res_   <= 1'b0;
      pmoden <= 1'b0;
      vccen  <= 1'b0;
    end else begin
      res_ <= 1'b1;
      if (wr && din[PWR]) begin
        pmoden <= din[0];
        vccen  <= din[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)      ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule
